// File: rtl/sdram_init_seq_if.sv
// sdram_init_seq_if: SDRAM pin bundle driven by the power-up init sequencer.
//   master modport (sequencer side): drives all pins
//   slave  modport (SDRAM / controller mux side): observes all pins
// Pins: DRAM_CLK, DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N,
//       DRAM_BA[BA_WIDTH], DRAM_ADDR[ADDR_WIDTH], DRAM_LDQM, DRAM_UDQM
interface sdram_init_seq_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int BA_WIDTH   = 2
) ();
  logic                  DRAM_CLK;
  logic                  DRAM_CKE;
  logic                  DRAM_CS_N;
  logic                  DRAM_RAS_N;
  logic                  DRAM_CAS_N;
  logic                  DRAM_WE_N;
  logic [BA_WIDTH-1:0]   DRAM_BA;
  logic [ADDR_WIDTH-1:0] DRAM_ADDR;
  logic                  DRAM_LDQM;
  logic                  DRAM_UDQM;

  modport master (
    output DRAM_CLK, DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N,
           DRAM_BA, DRAM_ADDR, DRAM_LDQM, DRAM_UDQM
  );

  modport slave (
    input DRAM_CLK, DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N,
          DRAM_BA, DRAM_ADDR, DRAM_LDQM, DRAM_UDQM
  );
endinterface

// File: rtl/sdram_init_seq.sv
// sdram_init_seq: SDRAM power-up initialisation sequencer.
// Issues power-up wait, PRECHARGE ALL, REFRESH_COUNT x AUTO REFRESH, MODE
// REGISTER SET on registered command pins, then raises init_done.
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset (priority over enable)
//   enable       in   start/hold; low returns to IDLE with reset outputs
//   dram         if   SDRAM pins (master modport); DRAM_CLK = ~clock
//   init_done    out  sequence complete, bus handed over
//   refresh_busy out  periodic refresh in progress (AUTO_REFRESH_EN only)
// Optional feature macro: AUTO_REFRESH_EN (periodic AUTO REFRESH in DONE).
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | CKE low, pins deselected, waiting for enable
// S_WAIT_PU   | power-up wait running; PRECHARGE issued on expiry
// S_PRECHARGE | tRP running after PRECHARGE; first REFRESH on expiry
// S_REFRESH   | tRFC running; next REFRESH or MRS on expiry
// S_MRS       | tMRD running after MRS; DONE on expiry
// S_DONE      | init_done high, DQM released, NOP (or periodic refresh)
module sdram_init_seq #(
  parameter int                    CLK_PERIOD_NS    = 20,
  parameter int                    POWERUP_NS       = 200000,
  parameter int                    T_RP_CYCLES      = 2,
  parameter int                    T_RFC_CYCLES     = 4,
  parameter int                    T_MRD_CYCLES     = 2,
  parameter int                    REFRESH_COUNT    = 2,
  parameter int                    ADDR_WIDTH       = 13,
  parameter int                    BA_WIDTH         = 2,
  parameter logic [ADDR_WIDTH-1:0] MODE_REG         = 'h022,
  parameter int                    REFRESH_INTERVAL = 390
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  sdram_init_seq_if.master dram,
  output logic             init_done
`ifdef AUTO_REFRESH_EN
  ,
  output logic             refresh_busy
`endif
);

  localparam int P = (POWERUP_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
`ifdef AUTO_REFRESH_EN
  localparam int IVL_WAIT = REFRESH_INTERVAL;
`else
  localparam int IVL_WAIT = 1;
`endif
  localparam int M1 = (P > T_RP_CYCLES) ? P : T_RP_CYCLES;
  localparam int M2 = (M1 > T_RFC_CYCLES) ? M1 : T_RFC_CYCLES;
  localparam int M3 = (M2 > T_MRD_CYCLES) ? M2 : T_MRD_CYCLES;
  localparam int MAX_WAIT = (M3 > IVL_WAIT) ? M3 : IVL_WAIT;
  localparam int TW = $clog2(MAX_WAIT + 1);

  localparam logic [3:0] CMD_DESL = 4'b1111;
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  if (CLK_PERIOD_NS < 1 || P < 1) begin : g_bad_pu
    $error("sdram_init_seq: power-up wait must be at least one cycle");
  end
  if (T_RP_CYCLES < 1 || T_RFC_CYCLES < 1 || T_MRD_CYCLES < 1) begin : g_bad_t
    $error("sdram_init_seq: timing parameters must be >= 1");
  end
  if (REFRESH_COUNT < 1 || REFRESH_COUNT > 15) begin : g_bad_rc
    $error("sdram_init_seq: REFRESH_COUNT must be 1..15");
  end
  if (ADDR_WIDTH < 11 || BA_WIDTH < 1) begin : g_bad_w
    $error("sdram_init_seq: ADDR_WIDTH must be >= 11, BA_WIDTH >= 1");
  end
`ifdef AUTO_REFRESH_EN
  // A new refresh must not land while the previous tRFC is still running.
  if (REFRESH_INTERVAL < T_RFC_CYCLES) begin : g_bad_ivl
    $error("sdram_init_seq: REFRESH_INTERVAL must be >= T_RFC_CYCLES");
  end
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PU, S_PRECHARGE, S_REFRESH, S_MRS, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [3:0]            ref_cnt_q, ref_cnt_d;
  logic                  cke_q, cke_d;
  logic [3:0]            cmd_q, cmd_d;
  logic [BA_WIDTH-1:0]   ba_q, ba_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  dqm_q, dqm_d;
  logic                  done_q, done_d;
  logic                  tmr_zero;
`ifdef AUTO_REFRESH_EN
  logic [TW-1:0]         ivl_q, ivl_d;
  logic [TW-1:0]         busy_cnt_q, busy_cnt_d;
  logic                  busy_q, busy_d;
`endif

  assign tmr_zero = (tmr_q == '0);

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    ref_cnt_d = ref_cnt_q;
    cke_d     = 1'b1;
    cmd_d     = CMD_NOP;
    ba_d      = '0;
    addr_d    = '0;
    dqm_d     = 1'b1;
    done_d    = 1'b0;
`ifdef AUTO_REFRESH_EN
    ivl_d      = ivl_q;
    busy_cnt_d = busy_cnt_q;
    busy_d     = 1'b0;
`endif
    if (!enable) begin
      state_d   = S_IDLE;
      tmr_d     = '0;
      ref_cnt_d = '0;
      cke_d     = 1'b0;
      cmd_d     = CMD_DESL;
`ifdef AUTO_REFRESH_EN
      ivl_d      = '0;
      busy_cnt_d = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_WAIT_PU;
          tmr_d     = TW'(P - 1);
          ref_cnt_d = '0;
        end
        S_WAIT_PU: begin
          if (tmr_zero) begin
            cmd_d      = CMD_PRE;
            addr_d[10] = 1'b1;
            state_d    = S_PRECHARGE;
            tmr_d      = TW'(T_RP_CYCLES - 1);
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        S_PRECHARGE: begin
          if (tmr_zero) begin
            cmd_d     = CMD_REF;
            ref_cnt_d = 4'd1;
            state_d   = S_REFRESH;
            tmr_d     = TW'(T_RFC_CYCLES - 1);
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        S_REFRESH: begin
          if (tmr_zero) begin
            if (ref_cnt_q == 4'(REFRESH_COUNT)) begin
              cmd_d   = CMD_MRS;
              addr_d  = MODE_REG;
              state_d = S_MRS;
              tmr_d   = TW'(T_MRD_CYCLES - 1);
            end else begin
              cmd_d     = CMD_REF;
              ref_cnt_d = ref_cnt_q + 4'd1;
              tmr_d     = TW'(T_RFC_CYCLES - 1);
            end
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        S_MRS: begin
          if (tmr_zero) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            dqm_d   = 1'b0;
`ifdef AUTO_REFRESH_EN
            ivl_d   = TW'(REFRESH_INTERVAL - 1);
`endif
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        S_DONE: begin
          done_d = 1'b1;
          dqm_d  = 1'b0;
`ifdef AUTO_REFRESH_EN
          // busy covers the command cycle plus T_RFC_CYCLES-1 after it
          if (busy_cnt_q != '0) begin
            busy_d     = 1'b1;
            busy_cnt_d = busy_cnt_q - TW'(1);
          end
          if (ivl_q == '0) begin
            cmd_d      = CMD_REF;
            ivl_d      = TW'(REFRESH_INTERVAL - 1);
            busy_d     = 1'b1;
            busy_cnt_d = TW'(T_RFC_CYCLES - 1);
          end else begin
            ivl_d = ivl_q - TW'(1);
          end
`endif
        end
        default: begin
          state_d = S_IDLE;
          cke_d   = 1'b0;
          cmd_d   = CMD_DESL;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      ref_cnt_q <= '0;
      cke_q     <= 1'b0;
      cmd_q     <= CMD_DESL;
      ba_q      <= '0;
      addr_q    <= '0;
      dqm_q     <= 1'b1;
      done_q    <= 1'b0;
`ifdef AUTO_REFRESH_EN
      ivl_q      <= '0;
      busy_cnt_q <= '0;
      busy_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      ref_cnt_q <= ref_cnt_d;
      cke_q     <= cke_d;
      cmd_q     <= cmd_d;
      ba_q      <= ba_d;
      addr_q    <= addr_d;
      dqm_q     <= dqm_d;
      done_q    <= done_d;
`ifdef AUTO_REFRESH_EN
      ivl_q      <= ivl_d;
      busy_cnt_q <= busy_cnt_d;
      busy_q     <= busy_d;
`endif
    end
  end

  assign dram.DRAM_CLK   = ~clock;
  assign dram.DRAM_CKE   = cke_q;
  assign dram.DRAM_CS_N  = cmd_q[3];
  assign dram.DRAM_RAS_N = cmd_q[2];
  assign dram.DRAM_CAS_N = cmd_q[1];
  assign dram.DRAM_WE_N  = cmd_q[0];
  assign dram.DRAM_BA    = ba_q;
  assign dram.DRAM_ADDR  = addr_q;
  assign dram.DRAM_LDQM  = dqm_q;
  assign dram.DRAM_UDQM  = dqm_q;
  assign init_done       = done_q;
`ifdef AUTO_REFRESH_EN
  assign refresh_busy    = busy_q;
`endif

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: three instances with different parameter sets
// checked every cycle against a timeline model, plus a vector table and
// directed sequences.
module tb_sdram_init_seq;

  typedef struct packed {
    logic        cke;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic [1:0]  dqm;
    logic        done;
    logic        busy;
  } obs_t;

  typedef struct {
    logic       rst;
    logic       en;
    logic       cke;
    logic [3:0] cmd;
    logic       done;
  } vec_t;

  localparam int PP  [3] = '{(200000 + 19) / 20, (110 + 19) / 20, (100 + 19) / 20};
  localparam int TRP [3] = '{2, 2, 2};
  localparam int TRFC[3] = '{4, 4, 7};
  localparam int TMRD[3] = '{2, 2, 2};
  localparam int RC  [3] = '{2, 2, 8};
  localparam int IVL [3] = '{390, 50, 50};

  logic       clock;
  logic [2:0] rst, en, done, busy;
  int         n [3];
  int         checks, failures;
  obs_t       o [3];
  vec_t       vq[$];

  sdram_init_seq_if #(.ADDR_WIDTH(13), .BA_WIDTH(2)) if0 ();
  sdram_init_seq_if #(.ADDR_WIDTH(13), .BA_WIDTH(2)) if1 ();
  sdram_init_seq_if #(.ADDR_WIDTH(13), .BA_WIDTH(2)) if2 ();

  sdram_init_seq u0 (
    .clock(clock), .reset(rst[0]), .enable(en[0]), .dram(if0), .init_done(done[0])
`ifdef AUTO_REFRESH_EN
    , .refresh_busy(busy[0])
`endif
  );

  sdram_init_seq #(.POWERUP_NS(110), .REFRESH_INTERVAL(50)) u1 (
    .clock(clock), .reset(rst[1]), .enable(en[1]), .dram(if1), .init_done(done[1])
`ifdef AUTO_REFRESH_EN
    , .refresh_busy(busy[1])
`endif
  );

  sdram_init_seq #(.POWERUP_NS(100), .REFRESH_COUNT(8), .T_RFC_CYCLES(7),
                   .REFRESH_INTERVAL(50)) u2 (
    .clock(clock), .reset(rst[2]), .enable(en[2]), .dram(if2), .init_done(done[2])
`ifdef AUTO_REFRESH_EN
    , .refresh_busy(busy[2])
`endif
  );

`ifndef AUTO_REFRESH_EN
  assign busy = '0;
`endif

  assign o[0] = {if0.DRAM_CKE, if0.DRAM_CS_N, if0.DRAM_RAS_N, if0.DRAM_CAS_N, if0.DRAM_WE_N,
                 if0.DRAM_ADDR, if0.DRAM_BA, if0.DRAM_LDQM, if0.DRAM_UDQM, done[0], busy[0]};
  assign o[1] = {if1.DRAM_CKE, if1.DRAM_CS_N, if1.DRAM_RAS_N, if1.DRAM_CAS_N, if1.DRAM_WE_N,
                 if1.DRAM_ADDR, if1.DRAM_BA, if1.DRAM_LDQM, if1.DRAM_UDQM, done[1], busy[1]};
  assign o[2] = {if2.DRAM_CKE, if2.DRAM_CS_N, if2.DRAM_RAS_N, if2.DRAM_CAS_N, if2.DRAM_WE_N,
                 if2.DRAM_ADDR, if2.DRAM_BA, if2.DRAM_LDQM, if2.DRAM_UDQM, done[2], busy[2]};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Expected pins 'n' edges after the enabling edge (n<0: idle/reset),
  // derived directly from the command timeline.
  function automatic obs_t model(int nn, int p, int trp, int trfc, int tmrd, int r, int ivl);
    obs_t e;
    int   m, d;
    e.cke = 1'b0; e.cmd = 4'hF; e.addr = '0; e.ba = '0;
    e.dqm = 2'b11; e.done = 1'b0; e.busy = 1'b0;
    if (nn < 0) return e;
    e.cke = 1'b1;
    e.cmd = 4'h7;
    m = p + trp + r * trfc;
    d = m + tmrd;
    if (nn == p) begin e.cmd = 4'h2; e.addr = 13'h400; end
    for (int k = 1; k <= r; k++)
      if (nn == p + trp + (k - 1) * trfc) e.cmd = 4'h1;
    if (nn == m) begin e.cmd = 4'h0; e.addr = 13'h022; end
    if (nn >= d) begin
      e.done = 1'b1;
      e.dqm  = 2'b00;
`ifdef AUTO_REFRESH_EN
      if (nn > d && (nn - d) % ivl == 0) e.cmd = 4'h1;
      if (nn >= d + ivl && (nn - d) % ivl < trfc) e.busy = 1'b1;
`else
      if (ivl < 0) e.busy = 1'b1;
`endif
    end
    return e;
  endfunction

  function void add(logic r, logic e, logic c, logic [3:0] cm, logic dn);
    vec_t v;
    v.rst = r; v.en = e; v.cke = c; v.cmd = cm; v.done = dn;
    vq.push_back(v);
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i] || !en[i]) n[i] = -1;
      else if (n[i] < 0)    n[i] = 0;
      else                  n[i] = n[i] + 1;
    end
  end

  always @(negedge clock) begin
    obs_t e;
    for (int i = 0; i < 3; i++) begin
      e = model(n[i], PP[i], TRP[i], TRFC[i], TMRD[i], RC[i], IVL[i]);
      checks++;
      if (o[i] !== e) begin
        failures++;
        if (failures <= 20)
          $display("FAIL model dut%0d n=%0d got=%h exp=%h", i, n[i], o[i], e);
      end
    end
    checks++;
    if (if0.DRAM_CLK !== 1'b1) begin
      failures++;
      if (failures <= 20) $display("FAIL dram_clk got=%b exp=1", if0.DRAM_CLK);
    end
  end

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  initial begin
    int pre_at, done_at, cnt0, cnt2;
    for (int i = 0; i < 3; i++) n[i] = -1;
    checks = 0; failures = 0;
    rst = '1; en = '0;
    repeat (3) @(posedge clock);
    #1 rst = '0;

    // u1 (P=6, tRP=2, tRFC=4, R=2, tMRD=2): reset priority and abort/restart
    add(1, 0, 0, 4'hF, 0);
    add(0, 1, 1, 4'h7, 0);
    add(0, 1, 1, 4'h7, 0);
    add(1, 1, 0, 4'hF, 0);
    for (int i = 0; i < 6; i++) add(0, 1, 1, 4'h7, 0);
    add(0, 1, 1, 4'h2, 0);
    add(0, 1, 1, 4'h7, 0);
    add(0, 1, 1, 4'h1, 0);
    add(0, 0, 0, 4'hF, 0);
    for (int i = 0; i < 6; i++) add(0, 1, 1, 4'h7, 0);
    add(0, 1, 1, 4'h2, 0);
    add(0, 1, 1, 4'h7, 0);
    add(0, 1, 1, 4'h1, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 4'h7, 0);
    add(0, 1, 1, 4'h1, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 4'h7, 0);
    add(0, 1, 1, 4'h0, 0);
    add(0, 1, 1, 4'h7, 0);
    add(0, 1, 1, 4'h7, 1);
    for (int i = 0; i < vq.size(); i++) begin
      rst[1] = vq[i].rst;
      en[1]  = vq[i].en;
      @(posedge clock);
      #1;
      checks++;
      if (o[1].cke !== vq[i].cke || o[1].cmd !== vq[i].cmd || o[1].done !== vq[i].done) begin
        failures++;
        $display("FAIL vec%0d got cke=%b cmd=%h done=%b exp cke=%b cmd=%h done=%b",
                 i, o[1].cke, o[1].cmd, o[1].done, vq[i].cke, vq[i].cmd, vq[i].done);
      end
    end

    // Full default sequence on u0, long run of u2 and u1 alongside
    en = '1;
    pre_at = -1; done_at = -1; cnt0 = 0; cnt2 = 0;
    for (int k = 0; k < 10030; k++) begin
      @(posedge clock);
      #1;
      if (pre_at < 0 && o[0].cmd == 4'h2) pre_at = k;
      if (done_at < 0 && o[0].done) done_at = k;
      if (!o[0].done && o[0].cmd[3] == 1'b0 && o[0].cmd != 4'h7) cnt0++;
      if (!o[2].done && o[2].cmd == 4'h1) cnt2++;
    end
    chk("u0_precharge_edge", pre_at, 10000);
    chk("u0_done_edge", done_at, 10012);
    chk("u0_init_cmd_count", cnt0, 4);
    chk("u2_refresh_count", cnt2, 8);

    // Random enable/reset activity, checked by the timeline model
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < 3; i++) begin
        en[i]  = ($urandom_range(0, 3) != 0);
        rst[i] = ($urandom_range(0, 9) == 0);
      end
      repeat ($urandom_range(1, 80)) @(posedge clock);
      #1;
    end

    // Let u1 sit in DONE through several refresh intervals
    rst = '0;
    en  = 3'b010;
    repeat (220) @(posedge clock);
    #1;
    chk("u1_done_final", int'(done[1]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_init_seq.md
Name: sdram_init_seq

Overview:
Parametrised SDRAM power-up initialisation sequencer; successor to the fixed-timing init block. Generates the JEDEC init sequence on registered command pins:
- power-up wait
- PRECHARGE ALL
- N× AUTO REFRESH
- MODE REGISTER SET

Timing, refresh count, mode word and bus widths are parameters. Asserts init_done for the downstream SDRAM controller, which takes over the bus afterwards. Sits between the board clock domain and the SDRAM pins.

Parameters:
CLK_PERIOD_NS, 20, clock period in ns
POWERUP_NS, 200000, power-up stabilisation wait in ns; P = ceil(POWERUP_NS/CLK_PERIOD_NS) cycles
T_RP_CYCLES, 2, cycles from PRECHARGE to next command (>=1)
T_RFC_CYCLES, 4, cycles from AUTO REFRESH to next command (>=1)
T_MRD_CYCLES, 2, cycles from MRS to init_done (>=1)
REFRESH_COUNT, 2, number of init AUTO REFRESH commands (1..15)
ADDR_WIDTH, 13, DRAM_ADDR width (>=11)
BA_WIDTH, 2, DRAM_BA width
MODE_REG, 13'h022, mode word on ADDR during MRS (BL=4, sequential, CL=2)
REFRESH_INTERVAL, 390, cycles between periodic refreshes (AUTO_REFRESH_EN only)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  start/hold sequence; low aborts to idle
DRAM_CLK  output  1  ~clock
DRAM_CKE  output  1  clock enable
DRAM_CS_N  output  1  chip select
DRAM_RAS_N  output  1  row strobe
DRAM_CAS_N  output  1  column strobe
DRAM_WE_N  output  1  write enable
DRAM_BA  output  BA_WIDTH  bank address
DRAM_ADDR  output  ADDR_WIDTH  address
DRAM_LDQM  output  1  low byte mask
DRAM_UDQM  output  1  high byte mask
init_done  output  1  sequence complete, bus handed over
refresh_busy  output  1  periodic refresh in progress (present only with AUTO_REFRESH_EN)

Behaviour:
- All outputs except DRAM_CLK registered.
- Reset values:
  - CKE=0
  - CS_N/RAS_N/CAS_N/WE_N=1
  - BA=0, ADDR=0
  - LDQM=UDQM=1
  - init_done=0, refresh_busy=0
  - state=IDLE, counters=0
- Encodings {CS_N,RAS_N,CAS_N,WE_N}:
  - NOP=0111
  - PRECHARGE ALL=0010 (ADDR[10]=1, other ADDR bits 0)
  - AUTO REFRESH=0001
  - MRS=0000 (BA=0, ADDR=MODE_REG)
- Each command lasts exactly one cycle; NOP otherwise. DQM=1 throughout init.
- States and transitions:
  - IDLE: CKE=0, NOP, init_done=0. Enable sampled high → WAIT_PU, CKE=1 from next cycle.
  - WAIT_PU: count P cycles → PRECHARGE.
  - PRECHARGE: issue, wait T_RP_CYCLES → REFRESH.
  - REFRESH: issue, wait T_RFC_CYCLES; refresh counter increments; repeat until REFRESH_COUNT issued → MRS.
  - MRS: issue, wait T_MRD_CYCLES → DONE.
  - DONE: init_done=1, NOP, DQM=0, CKE=1; held while enable=1.
- Timing, E0 = first edge with enable=1 in IDLE:
  - PRECHARGE on outputs after edge E0+P
  - k-th REFRESH (k=1..R) after edge E0+P+T_RP+(k-1)·T_RFC
  - MRS after edge E0+P+T_RP+R·T_RFC
  - init_done rises after edge MRS_edge+T_MRD
- enable low in any state: next edge → IDLE, reset values on outputs, counters cleared. Re-enable restarts from WAIT_PU; no partial resume.
- reset has priority over enable.
- P computed at elaboration; must be >=1.
- Illegal parameter values (timing <1, REFRESH_COUNT outside 1..15, ADDR_WIDTH<11): elaboration $error.
- Counters sized by $clog2 of largest wait; no wrap within a sequence.

Optional Feature:
AUTO_REFRESH_EN
- Defined:
  - In DONE, interval counter counts REFRESH_INTERVAL cycles, then issues one AUTO REFRESH.
  - refresh_busy=1 for that cycle plus T_RFC_CYCLES-1 following cycles; init_done stays 1.
  - Counter reloads on the command edge.
  - Counter and refresh_busy cleared by reset/enable low.
- Undefined: refresh_busy port absent; DONE emits NOP indefinitely.

Test Plan:
1. Defaults, reset 3 cycles, enable=1 → PRECHARGE (0010, ADDR[10]=1) after edge 10000; REFRESH after 10002 and 10006; MRS ADDR=0x022 BA=0 after 10010; init_done=1 after 10012; exactly 4 non-NOP commands.
2. POWERUP_NS=110, CLK_PERIOD_NS=20 → P=6; PRECHARGE after edge E0+6.
3. POWERUP_NS=100, REFRESH_COUNT=8, T_RFC_CYCLES=7 → exactly 8 REFRESH 7 cycles apart; MRS 7 cycles after the last.
4. Drop enable one cycle after the first REFRESH → next edge CKE=0, NOP, init_done=0; re-enable → full sequence, PRECHARGE P edges later.
5. Reset asserted with enable=1 mid-WAIT_PU → all outputs at reset values next edge; reset priority over enable confirmed.
6. AUTO_REFRESH_EN, REFRESH_INTERVAL=50, T_RFC_CYCLES=4 → after init_done, AUTO REFRESH every 50 cycles; refresh_busy high 4 cycles each; init_done never drops.
